lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Load/store unit directly upstream of the data RAM stage.
- Accepts one memory request at a time from the execute stage over a valid/ready handshake.
- Drives the RAM write and read ports, waits a configurable latency, then lane-selects and sign- or zero-extends load data.
- Presents the result to write-back over a second valid/ready handshake. Also flags misaligned and illegal accesses.

Parameters:
LATENCY, 1, memory access cycles spent in WAIT (legal range 1..15).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept a request
req_wen  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  write-back accepts response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or illegal-funct3 access
mem_wen  out  1  RAM write enable, sampled on clk rising edge
mem_len  out  2  access size as log2(bytes): 0 byte, 1 half, 2 word
mem_waddr  out  32  RAM write byte address (exact, unaligned)
mem_wdata  out  32  RAM write data, right-aligned
mem_raddr  out  32  RAM read address, always word-aligned
mem_rdata  in  32  RAM combinational read data (full word at mem_raddr)

Behaviour:
- States: IDLE, WAIT, RESP. A 4-bit down-counter cnt is used in WAIT.
- Reset (async, rst_n=0), all cleared immediately:
  - state=IDLE, cnt=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - mem_wen=0, mem_len=0, mem_waddr=0, mem_wdata=0, mem_raddr=0.
- IDLE:
  - req_ready=1. No other state asserts req_ready.
  - On req_valid&req_ready, latch wen, funct3, addr, wdata.
  - Error check: funct3 not in {000,001,010,100,101}, or store funct3 in {100,101}, or half with addr[0]=1, or word with addr[1:0]!=0.
  - If the check fails: go to RESP with rsp_err=1, rsp_rdata=0. No RAM access is made.
  - Otherwise: go to WAIT with cnt=LATENCY-1.
- WAIT:
  - mem_raddr = {addr[31:2],2'b00}; mem_len = funct3[1:0].
  - mem_waddr = addr; mem_wdata = wdata masked to the access width.
  - If cnt!=0, decrement cnt.
  - If cnt==0 and the op is a store: mem_wen=1 for exactly this one cycle (write commits on the edge leaving WAIT). Go to RESP with rsp_rdata=0, rsp_err=0.
  - If cnt==0 and the op is a load: select lane from mem_rdata.
    - Byte: mem_rdata[8*addr[1:0]+:8].
    - Half: mem_rdata[16*addr[1]+:16].
    - Word: full mem_rdata.
    - Sign-extend for 000/001, zero-extend for 100/101.
    - Register the result into rsp_rdata. Go to RESP.
- mem_wen is 0 in every state other than the final WAIT cycle of a store, and 0 during reset.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable while rsp_ready=0.
  - On rsp_ready=1: rsp_valid drops at the next edge and state goes to IDLE.
- Latency: rsp_valid rises LATENCY cycles after the accept edge.
  - Error responses take 1 cycle.
  - Back-to-back throughput is one op per LATENCY+2 cycles. There is no overlap: the next request is accepted only in IDLE.
- mem_raddr, mem_waddr and mem_len hold their last values in IDLE and RESP. mem_wdata is don't-care there.
- Reset mid-WAIT: the op is aborted and no write is issued; a store in its final cycle is also suppressed. No response is produced.
- req_* inputs are ignored outside IDLE. Changes after acceptance have no effect.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-WAIT of a store with LATENCY=3.
  - Required response: mem_wen stays 0, RAM word unchanged, rsp_valid=0, req_ready=1 after release.
- Store word then load word:
  - Stimulus: sw 0xDEADBEEF @0x80000010, then lw @0x80000010, LATENCY=1.
  - Required response: mem_wen high exactly 1 cycle, mem_len=2; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 1 cycle after accept.
- Byte lanes and extension:
  - Stimulus: word 0x80FF7F01 @0x100.
  - Required response: lb@0x101 -> 0x0000007F; lb@0x103 -> 0xFFFFFF80; lbu@0x103 -> 0x00000080; lh@0x102 -> 0xFFFF80FF; lhu@0x102 -> 0x000080FF. mem_raddr=0x100 in all cases.
- Misaligned and illegal:
  - Stimulus: lw@0x102; sh@0x101; funct3=011 load.
  - Required response: rsp_err=1, rsp_rdata=0, mem_wen never asserted, response 1 cycle after accept.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles after lw returns 0x12345678.
  - Required response: rsp_valid and rsp_rdata stable; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Latency sweep:
  - Stimulus: LATENCY=4, sw 0xA5 as sb @0x203, then lbu @0x203.
  - Required response: mem_wen asserted in the 4th WAIT cycle only, with mem_waddr=0x203, mem_len=0, mem_wdata=0x000000A5; load returns 0x000000A5 exactly 4 cycles after accept.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Load/store unit feeding the data RAM: one request in flight,
// fixed-latency access, lane select and extension of load data.
module lsu_mem_stage #(
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_wen,
   output logic [1:0]  mem_len,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_raddr,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  cnt_q;
   logic [3:0]  cnt_d;
   logic        wen_q;
   logic        uns_q;
   logic        bad;
   logic        fire;
   logic        go;
   logic        done;
   logic [31:0] wmask;
   logic [31:0] sh;
   logic [31:0] ld;

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign fire      = req_valid && (state_q == IDLE);
   assign go        = fire && !bad;
   assign done      = (state_q == WAIT) && (cnt_q == 4'd0);
   assign mem_wen   = done && wen_q;

   always_comb begin
      bad = 1'b0;
      unique case (req_funct3)
         3'b000:         bad = 1'b0;
         3'b001:         bad = req_addr[0];
         3'b010:         bad = |req_addr[1:0];
         3'b100, 3'b101: bad = req_wen | (req_funct3[0] & req_addr[0]);
         default:        bad = 1'b1;
      endcase
   end

   always_comb begin
      wmask = 32'hFFFF_FFFF;
      unique case (req_funct3[1:0])
         2'b00:   wmask = 32'h0000_00FF;
         2'b01:   wmask = 32'h0000_FFFF;
         default: wmask = 32'hFFFF_FFFF;
      endcase
   end

   // Halves are 2-byte aligned, so one byte-granular shift serves both widths.
   assign sh = mem_rdata >> {mem_waddr[1:0], 3'b000};

   always_comb begin
      ld = mem_rdata;
      unique case (mem_len)
         2'b00:   ld = uns_q ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         2'b01:   ld = uns_q ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: ld = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (fire) begin
               state_d = bad ? RESP : WAIT;
               cnt_d   = bad ? cnt_q : CNT_INIT;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen_q     <= 1'b0;
         uns_q     <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
         mem_len   <= 2'd0;
         mem_waddr <= 32'd0;
         mem_wdata <= 32'd0;
         mem_raddr <= 32'd0;
      end else begin
         if (go) begin
            wen_q     <= req_wen;
            uns_q     <= req_funct3[2];
            mem_len   <= req_funct3[1:0];
            mem_waddr <= req_addr;
            mem_wdata <= req_wdata & wmask;
            mem_raddr <= {req_addr[31:2], 2'b00};
         end
         if (fire && bad) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b1;
         end
         if (done) begin
            rsp_rdata <= wen_q ? 32'd0 : ld;
            rsp_err   <= 1'b0;
         end
      end
   end

endmodule
